core_data_port: RTL and testbench
=================================

# core_data_port

Parametrised data-side memory port for a PASC core, placed between the pipeline data interface, the core's local dual-port SRAM data port and the shared remote bus. Addresses whose top LOCAL_BITS bits are zero go to local memory with no stall. Remote writes are posted into a WBUF_DEPTH-entry write buffer so the pipeline does not wait on the bus. Remote reads stall the pipeline until the buffer has drained and the remote target responds.

## Interface
Parameters:
- DATA_WIDTH, 16, data word width
- ADDR_WIDTH, 16, word address width
- LOCAL_BITS, 2, top address bits that must be zero for a local access; must be ≥1
- LMEM_ADDR_WIDTH, 11, local memory address width; must be ≤ ADDR_WIDTH-LOCAL_BITS
- WBUF_DEPTH, 4, posted write buffer entries; power of two, ≥2

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- p_addr  in  ADDR_WIDTH  pipeline data address
- p_wdata  in  DATA_WIDTH  pipeline store data
- p_wren  in  1  pipeline store request
- p_rden  in  1  pipeline load request
- p_rdata  out  DATA_WIDTH  load data, valid the cycle after acceptance
- p_stall  out  1  pipeline must hold the current request
- lmem_addr  out  LMEM_ADDR_WIDTH  local memory address, p_addr[LMEM_ADDR_WIDTH-1:0]
- lmem_we  out  1  local memory write enable
- lmem_wdata  out  DATA_WIDTH  local memory write data, equal to p_wdata
- lmem_q  in  DATA_WIDTH  local memory read data, one-cycle latency
- remote_addr  out  ADDR_WIDTH  remote bus address
- remote_wren  out  1  remote write strobe
- remote_rden  out  1  remote read strobe
- remote_write_val  out  DATA_WIDTH  remote write data
- remote_ready  in  1  remote target completes the current strobe this cycle
- remote_read_val  in  DATA_WIDTH  remote read data, valid when remote_ready and remote_rden are both high
- wbuf_count  out  $clog2(WBUF_DEPTH)+1  occupied write buffer entries

## Operation
- Decode: local = (p_addr[ADDR_WIDTH-1 -: LOCAL_BITS] == 0).
- The pipeline never asserts p_wren and p_rden together. The bench flags it if it does.
- Local store: lmem_we = p_wren && local. No stall. No ordering is enforced against buffered remote writes, because the regions are disjoint.
- Local load: no stall. Register sel_l <= 1. p_rdata = lmem_q on the next cycle.
- Remote store, count < WBUF_DEPTH: push {p_addr, p_wdata} at the clock edge; p_stall = 0.
- Remote store, count == WBUF_DEPTH: p_stall = 1. This holds even if the head pops in the same cycle; the push is retried the next cycle.
- Drain: whenever count > 0, the head entry drives remote_addr and remote_write_val with remote_wren = 1. The entry pops on a cycle with remote_ready = 1. Entries drain in FIFO order.
- Remote load, count > 0: p_stall = 1 and remote_rden = 0. Draining continues.
- Remote load, count == 0: remote_rden = 1 and remote_addr = p_addr.
  - p_stall = !remote_ready.
  - When remote_ready = 1, capture remote_read_val into rdata_r and set sel_l <= 0.
  - p_rdata = rdata_r on the next cycle.
- remote_wren and remote_rden are never high together.
- p_rdata is a combinational mux: sel_l ? lmem_q : rdata_r.
- sel_l updates only on an accepted load (a load with p_stall = 0). Otherwise it holds.
- Idle bus (count == 0, no remote load): remote_wren = 0, remote_rden = 0, remote_addr = 0, remote_write_val = 0.
- Push and pop in the same cycle (count < WBUF_DEPTH): count is unchanged. Read and write pointers wrap modulo WBUF_DEPTH.

## Timing
- Reset values: count = 0, pointers = 0, rdata_r = 0, sel_l = 1. All remote strobes = 0, p_stall = 0, lmem_we = 0.
- Asserting reset mid-drain or mid-read discards all buffered entries and abandons the bus cycle. No strobe is asserted on the cycle after reset deasserts.
- Latency:
  - Local load: data 1 cycle after the request.
  - Remote load, empty buffer, remote_ready already high: data 1 cycle after the request.
  - Remote load, general case: data 1 cycle after the cycle with remote_ready high, which comes after count reaches 0.
- Remote store: 0 stall cycles when the buffer is not full. The write appears on the bus the cycle after the push at the earliest.
- p_stall is combinational from p_addr, p_wren, p_rden, count and remote_ready.
- remote_wren, remote_addr and remote_write_val during a drain depend only on registered state.

## Test plan
- Local round trip: store 0x1234 to 0x0010, then load 0x0010 → lmem_we pulses once, p_stall never asserts, p_rdata = 0x1234 the cycle after the load.
- Posted writes: 4 back-to-back stores to 0x8000..0x8003 with remote_ready = 0 → no stall and wbuf_count = 4. A 5th store stalls. After remote_ready = 1, the bus shows addresses 0x8000, 0x8001, 0x8002, 0x8003 in order and the 5th store is accepted.
- Read ordering: store 0xBEEF to 0x8004, then immediately load 0x8004 → remote_rden stays 0 until the write pops. The read then issues, and p_rdata = the value returned on remote_read_val.
- Remote read wait states: load 0xC000 with remote_ready low for 3 cycles, read value 0x5A5A → p_stall high for 3 cycles, p_rdata = 0x5A5A one cycle after ready.
- Simultaneous push and pop: buffer at 2, remote store in the same cycle as remote_ready = 1 → wbuf_count stays 2 and pointers wrap correctly over 10 iterations.
- Reset mid-drain: assert reset with 3 entries buffered → wbuf_count = 0, remote_wren = 0, p_rdata = 0 and no stale write is issued after release.

Source files
------------

// File: rtl/core_data_port_if.sv
// Signal bundle between the PASC pipeline data side, the local data SRAM port and
// the shared remote bus, as seen by core_data_port.
interface core_data_port_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 16,
  parameter int LMEM_ADDR_WIDTH = 11,
  parameter int WBUF_DEPTH      = 4
) ();
  // Pipeline: a request is held while p_stall is high and is accepted on the first
  // clock edge with p_stall low; load data appears on p_rdata the following cycle.
  // Remote bus: a strobe stays high until the edge on which remote_ready is high.
  logic [ADDR_WIDTH-1:0]           p_addr;
  logic [DATA_WIDTH-1:0]           p_wdata;
  logic                            p_wren;
  logic                            p_rden;
  logic [DATA_WIDTH-1:0]           p_rdata;
  logic                            p_stall;
  logic [LMEM_ADDR_WIDTH-1:0]      lmem_addr;
  logic                            lmem_we;
  logic [DATA_WIDTH-1:0]           lmem_wdata;
  logic [DATA_WIDTH-1:0]           lmem_q;
  logic [ADDR_WIDTH-1:0]           remote_addr;
  logic                            remote_wren;
  logic                            remote_rden;
  logic [DATA_WIDTH-1:0]           remote_write_val;
  logic                            remote_ready;
  logic [DATA_WIDTH-1:0]           remote_read_val;
  logic [$clog2(WBUF_DEPTH):0]     wbuf_count;

  modport slave (
    input  p_addr, p_wdata, p_wren, p_rden, lmem_q, remote_ready, remote_read_val,
    output p_rdata, p_stall, lmem_addr, lmem_we, lmem_wdata,
           remote_addr, remote_wren, remote_rden, remote_write_val, wbuf_count
  );

  modport master (
    output p_addr, p_wdata, p_wren, p_rden, lmem_q, remote_ready, remote_read_val,
    input  p_rdata, p_stall, lmem_addr, lmem_we, lmem_wdata,
           remote_addr, remote_wren, remote_rden, remote_write_val, wbuf_count
  );
endinterface

// File: rtl/core_data_port.sv
// Data-side memory port: local accesses go straight to the SRAM, remote stores are
// posted into a small FIFO, remote loads wait for the FIFO to drain and the bus.
module core_data_port #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 16,
  parameter int LOCAL_BITS      = 2,
  parameter int LMEM_ADDR_WIDTH = 11,
  parameter int WBUF_DEPTH      = 4
) (
  input  logic              clk,
  input  logic              reset,
  core_data_port_if.slave   bus
);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WBUF_DEPTH);

  logic [ADDR_WIDTH-1:0] r_wb_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] r_wb_data [WBUF_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_sel_l;

  logic w_local;
  logic w_st_remote;
  logic w_ld_remote;
  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_rd_done;
  logic w_stall;
  logic w_ld_accept;

  assign w_local     = (bus.p_addr[ADDR_WIDTH-1 -: LOCAL_BITS] == '0);
  assign w_st_remote = bus.p_wren && !w_local;
  assign w_ld_remote = bus.p_rden && !w_local;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL_CNT);

  // A full buffer stalls even when the head pops this cycle; the push retries next cycle.
  assign w_push      = w_st_remote && !w_full;
  assign w_pop       = !w_empty && bus.remote_ready;
  assign w_rd_done   = w_ld_remote && w_empty && bus.remote_ready;

  assign w_stall     = (w_st_remote && w_full) ||
                       (w_ld_remote && (!w_empty || !bus.remote_ready));
  assign w_ld_accept = bus.p_rden && !w_stall;

  assign bus.p_stall    = w_stall;
  assign bus.p_rdata    = r_sel_l ? bus.lmem_q : r_rdata;
  assign bus.lmem_addr  = bus.p_addr[LMEM_ADDR_WIDTH-1:0];
  assign bus.lmem_we    = bus.p_wren && w_local;
  assign bus.lmem_wdata = bus.p_wdata;
  assign bus.wbuf_count = r_count;

  // Buffered writes own the bus until drained, so a remote load can never overtake them.
  always_comb begin
    bus.remote_wren      = 1'b0;
    bus.remote_rden      = 1'b0;
    bus.remote_addr      = '0;
    bus.remote_write_val = '0;
    if (!w_empty) begin
      bus.remote_wren      = 1'b1;
      bus.remote_addr      = r_wb_addr[r_rptr];
      bus.remote_write_val = r_wb_data[r_rptr];
    end else if (w_ld_remote) begin
      bus.remote_rden = 1'b1;
      bus.remote_addr = bus.p_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_addr[r_wptr] <= bus.p_addr;
      r_wb_data[r_wptr] <= bus.p_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
      r_sel_l <= 1'b1;
    end else begin
      if (w_rd_done)   r_rdata <= bus.remote_read_val;
      if (w_ld_accept) r_sel_l <= w_local;
    end
  end
endmodule

// File: tb/tb_core_data_port.sv
// Bench for core_data_port: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the port's behaviour.
module tb_core_data_port;
  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int LB  = 2;
  localparam int LAW = 11;
  localparam int WD  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  core_data_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LMEM_ADDR_WIDTH(LAW),
                      .WBUF_DEPTH(WD)) bus_if ();

  core_data_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCAL_BITS(LB),
                   .LMEM_ADDR_WIDTH(LAW), .WBUF_DEPTH(WD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- local SRAM (one-cycle read latency) ----------------
  logic [DW-1:0] sram [1<<LAW];
  always @(posedge clk) begin
    if (reset) begin
      foreach (sram[i]) sram[i] <= '0;
      bus_if.lmem_q <= '0;
    end else begin
      if (bus_if.lmem_we) sram[bus_if.lmem_addr] <= bus_if.lmem_wdata;
      bus_if.lmem_q <= sram[bus_if.lmem_addr];
    end
  end

  // ---------------- remote target ----------------
  logic          rr_rand = 1'b0;
  logic          f_ready = 1'b0;
  logic [DW-1:0] f_val   = '0;
  always @(posedge clk) begin
    #1;
    if (rr_rand) begin
      bus_if.remote_ready    = ($urandom_range(0, 9) < 6);
      bus_if.remote_read_val = DW'($urandom);
    end else begin
      bus_if.remote_ready    = f_ready;
      bus_if.remote_read_val = f_val;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [AW+DW-1:0] exp_q [$];
  logic [DW-1:0]    shadow [int];
  logic [AW-1:0]    bus_log [$];
  logic             rd_pending = 1'b0;
  logic [DW-1:0]    rd_exp = '0;
  int               lmem_we_cnt = 0;
  int               stall_cnt = 0;

  logic             m_loc;
  int               m_cnt;
  int               m_idx;
  logic             m_stall;
  logic             m_rden;
  logic [AW-1:0]    m_raddr;
  logic [DW-1:0]    m_wval;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      shadow.delete();
      rd_pending = 1'b0;
      chk("rst_count", 32'(bus_if.wbuf_count), 0);
      chk("rst_wren", 32'(bus_if.remote_wren), 0);
      chk("rst_rden", 32'(bus_if.remote_rden), 0);
    end else begin
      if (bus_if.lmem_we) lmem_we_cnt++;
      if (bus_if.p_stall) stall_cnt++;
      if (bus_if.remote_wren && bus_if.remote_ready) bus_log.push_back(bus_if.remote_addr);
      chk("wr_rd_exclusive", 32'(bus_if.p_wren & bus_if.p_rden), 0);

      m_loc   = (bus_if.p_addr[AW-1 -: LB] == '0);
      m_cnt   = exp_q.size();
      m_idx   = int'(bus_if.p_addr[LAW-1:0]);
      m_stall = (bus_if.p_wren && !m_loc && m_cnt == WD) ||
                (bus_if.p_rden && !m_loc && (m_cnt > 0 || !bus_if.remote_ready));
      m_rden  = bus_if.p_rden && !m_loc && m_cnt == 0;
      m_raddr = (m_cnt > 0) ? exp_q[0][AW+DW-1:DW] : (m_rden ? bus_if.p_addr : '0);
      m_wval  = (m_cnt > 0) ? exp_q[0][DW-1:0] : '0;

      chk("p_stall", 32'(bus_if.p_stall), 32'(m_stall));
      chk("wbuf_count", 32'(bus_if.wbuf_count), 32'(m_cnt));
      chk("remote_wren", 32'(bus_if.remote_wren), 32'(m_cnt > 0));
      chk("remote_rden", 32'(bus_if.remote_rden), 32'(m_rden));
      chk("remote_addr", 32'(bus_if.remote_addr), 32'(m_raddr));
      chk("remote_write_val", 32'(bus_if.remote_write_val), 32'(m_wval));
      chk("lmem_we", 32'(bus_if.lmem_we), 32'(bus_if.p_wren && m_loc));
      chk("lmem_addr", 32'(bus_if.lmem_addr), 32'(m_idx));
      chk("lmem_wdata", 32'(bus_if.lmem_wdata), 32'(bus_if.p_wdata));
      if (rd_pending) chk("p_rdata", 32'(bus_if.p_rdata), 32'(rd_exp));

      // advance the model to the state after the coming edge
      rd_pending = 1'b0;
      if (bus_if.p_rden && !m_stall) begin
        rd_pending = 1'b1;
        if (m_loc) rd_exp = shadow.exists(m_idx) ? shadow[m_idx] : '0;
        else       rd_exp = bus_if.remote_read_val;
      end
      if (m_cnt > 0 && bus_if.remote_ready) void'(exp_q.pop_front());
      if (bus_if.p_wren && !m_loc && m_cnt < WD)
        exp_q.push_back({bus_if.p_addr, bus_if.p_wdata});
      if (bus_if.p_wren && m_loc) shadow[m_idx] = bus_if.p_wdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus_if.p_addr  = '0;
    bus_if.p_wdata = '0;
    bus_if.p_wren  = 1'b0;
    bus_if.p_rden  = 1'b0;
  endtask

  task automatic set_req(input logic wr, input logic rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus_if.p_addr  = a;
    bus_if.p_wdata = d;
    bus_if.p_wren  = wr;
    bus_if.p_rden  = rd;
  endtask

  // Holds the current request until an edge with p_stall low, then idles the pipeline.
  task automatic wait_accept();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus_if.p_stall) break;
    end
    chk("accept_in_budget", 32'(k < 200), 1);
    next_cycle();
    set_idle();
  endtask

  task automatic do_req(input logic wr, input logic rd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    set_req(wr, rd, a, d);
    wait_accept();
  endtask

  task automatic wait_drained();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus_if.wbuf_count == 0) break;
    end
    chk("drain_in_budget", 32'(k < 100), 1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int stalls;
    set_idle();
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;

    @(negedge clk);
    chk("reset_count", 32'(bus_if.wbuf_count), 0);
    chk("reset_stall", 32'(bus_if.p_stall), 0);
    chk("reset_lmem_we", 32'(bus_if.lmem_we), 0);
    chk("reset_p_rdata", 32'(bus_if.p_rdata), 0);
    next_cycle();

    // local round trip
    lmem_we_cnt = 0;
    stall_cnt = 0;
    do_req(1'b1, 1'b0, 16'h0010, 16'h1234);
    do_req(1'b0, 1'b1, 16'h0010, 16'h0000);
    @(negedge clk);
    chk("local_rt_data", 32'(bus_if.p_rdata), 32'h1234);
    chk("local_rt_we_pulses", 32'(lmem_we_cnt), 1);
    chk("local_rt_no_stall", 32'(stall_cnt), 0);
    next_cycle();

    // posted writes fill the buffer with the bus held off
    bus_log.delete();
    stall_cnt = 0;
    for (int i = 0; i < 4; i++) do_req(1'b1, 1'b0, 16'h8000 + 16'(i), 16'h1000 + 16'(i));
    chk("posted_no_stall", 32'(stall_cnt), 0);
    set_req(1'b1, 1'b0, 16'h8010, 16'h1010);
    @(negedge clk);
    chk("posted_count_full", 32'(bus_if.wbuf_count), 4);
    chk("posted_fifth_stalls", 32'(bus_if.p_stall), 1);
    f_ready = 1'b1;
    wait_accept();
    wait_drained();
    chk("posted_log_len", 32'(bus_log.size()), 5);
    if (bus_log.size() == 5) begin
      for (int i = 0; i < 4; i++) chk("posted_order", 32'(bus_log[i]), 32'h8000 + 32'(i));
      chk("posted_fifth_addr", 32'(bus_log[4]), 32'h8010);
    end

    // a remote load waits behind a buffered write
    f_ready = 1'b0;
    f_val = 16'hA5C3;
    next_cycle();
    do_req(1'b1, 1'b0, 16'h8004, 16'hBEEF);
    set_req(1'b0, 1'b1, 16'h8004, 16'h0000);
    @(negedge clk);
    chk("order_rden_held", 32'(bus_if.remote_rden), 0);
    chk("order_wren_first", 32'(bus_if.remote_wren), 1);
    f_ready = 1'b1;
    wait_accept();
    @(negedge clk);
    chk("order_read_data", 32'(bus_if.p_rdata), 32'hA5C3);

    // remote read with three wait states
    f_ready = 1'b0;
    f_val = 16'h5A5A;
    next_cycle();
    set_req(1'b0, 1'b1, 16'hC000, 16'h0000);
    stalls = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.p_stall) stalls++;
    end
    f_ready = 1'b1;
    wait_accept();
    @(negedge clk);
    chk("wait_stall_cycles", 32'(stalls), 3);
    chk("wait_read_data", 32'(bus_if.p_rdata), 32'h5A5A);

    // simultaneous push and pop keeps the occupancy steady across pointer wraps
    f_ready = 1'b0;
    next_cycle();
    do_req(1'b1, 1'b0, 16'h9000, 16'h2000);
    do_req(1'b1, 1'b0, 16'h9001, 16'h2001);
    @(negedge clk);
    chk("pushpop_start", 32'(bus_if.wbuf_count), 2);
    f_ready = 1'b1;
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      set_req(1'b1, 1'b0, 16'h9002 + 16'(i), 16'h2002 + 16'(i));
      @(negedge clk);
      chk("pushpop_count", 32'(bus_if.wbuf_count), 2);
      chk("pushpop_no_stall", 32'(bus_if.p_stall), 0);
      next_cycle();
    end
    set_idle();
    wait_drained();

    // reset while writes are still buffered
    f_ready = 1'b0;
    next_cycle();
    for (int i = 0; i < 3; i++) do_req(1'b1, 1'b0, 16'hA000 + 16'(i), 16'h3000 + 16'(i));
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_count", 32'(bus_if.wbuf_count), 0);
    chk("midrst_wren", 32'(bus_if.remote_wren), 0);
    @(negedge clk);
    chk("midrst_p_rdata", 32'(bus_if.p_rdata), 0);
    f_ready = 1'b1;
    @(posedge clk);
    #3 reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("postrst_no_stale_write", 32'(bus_if.remote_wren), 0);
    end
    next_cycle();

    // random traffic
    rr_rand = 1'b1;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0: next_cycle();
        1: do_req(1'b1, 1'b0, AW'($urandom_range(1, 63)), DW'($urandom));
        2: do_req(1'b0, 1'b1, AW'($urandom_range(1, 63)), '0);
        3, 4: do_req(1'b1, 1'b0, {2'($urandom_range(1, 3)), 14'($urandom)}, DW'($urandom));
        default: do_req(1'b0, 1'b1, {2'($urandom_range(1, 3)), 14'($urandom)}, '0);
      endcase
    end
    rr_rand = 1'b0;
    f_ready = 1'b1;
    wait_drained();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before the test completed");
    $fatal(1, "watchdog");
  end
endmodule
